queue_uart_tx: RTL

Byte-queue drain stage that pops 8-bit entries from the team's byte queue and transmits each as an asynchronous serial frame (8N1: 1 start bit, 8 data bits LSB first, 1 stop bit). It sits directly downstream of the queue, driving the queue's enable and read/write select lines and consuming its read data and empty flag. Frames are sent back-to-back with no idle gap while the queue holds data.

---
 rtl/queue_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/queue_uart_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// ============================================================================
// queue_pkg : shared types and constants for the byte-queue UART drain stage
// Rev 1.0
// ============================================================================
`default_nettype none

package queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// baud_tick_gen : bit-cycle counter, pulses bit_end on the last cycle of a bit
// Rev 1.0
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = enable && (cnt == LAST);

    // clear wins so a pop always starts the start bit on a fresh count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/queue_uart_tx.sv
// ============================================================================
// queue_uart_tx : pops bytes from the byte queue and sends them as 8N1 frames
// Rev 1.0
// ============================================================================
`default_nettype none

module queue_uart_tx
    import queue_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       q_empty_i,
    input  logic [7:0] q_data_i,
    output logic       q_en_o,
    output logic       q_rw_o,
    input  logic       hold_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       tx_n;
    logic       bit_end;
    logic       pop;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (Clk_i),
        .rst_n   (Rst_i),
        .clear   (pop),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    // Gating with Rst_i keeps q_en_o low while reset is held
    assign pop = Rst_i && !q_empty_i && !hold_i &&
                 ((state == IDLE) || ((state == STOP) && bit_end));

    assign q_en_o       = pop;
    assign q_rw_o       = 1'b0;
    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == STOP) && bit_end;

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_n   = START;
                    shift_n   = q_data_i;
                    bit_idx_n = '0;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (pop) begin
                    state_n   = START;
                    shift_n   = q_data_i;
                    bit_idx_n = '0;
                end else if (bit_end) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level follows the next state so tx_o changes on the same edge
    always_comb begin
        tx_n = 1'b1;
        if (state_n == START)     tx_n = 1'b0;
        else if (state_n == DATA) tx_n = shift_n[0];
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b1;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            tx_o    <= tx_n;
        end
    end

endmodule

`default_nettype wire
